// File: rtl/display_source_arbiter.sv
// display_source_arbiter: picks which requester (one-shot message, live keyboard,
// song playback) drives the 3-digit note/octave display. Priority is
// MSG > LIVE > PB. A released live note lingers for a hold window, and a
// message stays up for a fixed time. All outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing to show, outputs cleared
// LIVE      | outputs track the keyboard every cycle
// LIVE_HOLD | keyboard released, last live note frozen until the hold ends
// PB        | outputs track the playback engine every cycle
// MSG       | latched message fields shown for MSG_CYCLES cycles
module display_source_arbiter #(
  parameter int HOLD_CYCLES = 15_000_000,
  parameter int MSG_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       live_valid,
  input  logic [2:0] live_note_id,
  input  logic [1:0] live_semitone,
  input  logic       live_oct_up,
  input  logic       live_oct_down,
  input  logic       pb_valid,
  input  logic [2:0] pb_note_id,
  input  logic [1:0] pb_semitone,
  input  logic       pb_oct_up,
  input  logic       pb_oct_down,
  input  logic       msg_req,
  input  logic [2:0] msg_note_id,
  input  logic [1:0] msg_semitone,
  output logic       msg_ack,
  output logic [2:0] base_note_id_out,
  output logic [1:0] semitone_out,
  output logic       display_active,
  output logic       octave_up_out,
  output logic       octave_down_out,
  output logic [1:0] source_sel
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > MSG_CYCLES) ? HOLD_CYCLES : MSG_CYCLES;
  localparam int TW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
  // HOLD_CYCLES = 0 never loads the hold timer; keep the constant legal anyway.
  localparam logic [TW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;
  localparam logic [TW-1:0] MSG_LOAD  = TW'(MSG_CYCLES - 1);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LIVE = 2'b01;
  localparam logic [1:0] SEL_PB   = 2'b10;
  localparam logic [1:0] SEL_MSG  = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LIVE      = 3'd1,
    LIVE_HOLD = 3'd2,
    PB        = 3'd3,
    MSG       = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // The reserved semitone code 11 is shown as "no suffix".
  function automatic logic [1:0] clean_semi(input logic [1:0] s);
    return (s == 2'b11) ? 2'b00 : s;
  endfunction

  // Where to go (and what to show) when the display falls back to the
  // ordinary live-over-playback priority without any hold.
  state_t     pri_state;
  logic [2:0] pri_note;
  logic [1:0] pri_semi;
  logic       pri_active;
  logic       pri_up;
  logic       pri_down;
  logic [1:0] pri_sel;

  // Fallback selection among live, playback and nothing.
  always_comb begin
    pri_state  = IDLE;
    pri_note   = '0;
    pri_semi   = '0;
    pri_active = 1'b0;
    pri_up     = 1'b0;
    pri_down   = 1'b0;
    pri_sel    = SEL_NONE;
    if (live_valid) begin
      pri_state  = LIVE;
      pri_note   = live_note_id;
      pri_semi   = clean_semi(live_semitone);
      pri_active = 1'b1;
      pri_up     = live_oct_up;
      pri_down   = live_oct_down;
      pri_sel    = SEL_LIVE;
    end else if (pb_valid) begin
      pri_state  = PB;
      pri_note   = pb_note_id;
      pri_semi   = clean_semi(pb_semitone);
      pri_active = 1'b1;
      pri_up     = pb_oct_up;
      pri_down   = pb_oct_down;
      pri_sel    = SEL_PB;
    end
  end

  // Arbitration FSM with registered display outputs and message handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      msg_ack          <= 1'b0;
      base_note_id_out <= '0;
      semitone_out     <= '0;
      display_active   <= 1'b0;
      octave_up_out    <= 1'b0;
      octave_down_out  <= 1'b0;
      source_sel       <= SEL_NONE;
    end else begin
      msg_ack <= 1'b0;
      // A request still pending when a message expires is taken on that same
      // edge, so back-to-back messages run without a gap.
      if (msg_req && (state != MSG || timer == '0)) begin
        state            <= MSG;
        timer            <= MSG_LOAD;
        msg_ack          <= 1'b1;
        base_note_id_out <= msg_note_id;
        semitone_out     <= clean_semi(msg_semitone);
        display_active   <= 1'b1;
        octave_up_out    <= 1'b0;
        octave_down_out  <= 1'b0;
        source_sel       <= SEL_MSG;
      end else begin
        case (state)
          MSG: begin
            if (timer == '0) begin
              state            <= pri_state;
              base_note_id_out <= pri_note;
              semitone_out     <= pri_semi;
              display_active   <= pri_active;
              octave_up_out    <= pri_up;
              octave_down_out  <= pri_down;
              source_sel       <= pri_sel;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          LIVE: begin
            if (live_valid) begin
              base_note_id_out <= live_note_id;
              semitone_out     <= clean_semi(live_semitone);
              display_active   <= 1'b1;
              octave_up_out    <= live_oct_up;
              octave_down_out  <= live_oct_down;
              source_sel       <= SEL_LIVE;
            end else if (HOLD_CYCLES == 0) begin
              state            <= pri_state;
              base_note_id_out <= pri_note;
              semitone_out     <= pri_semi;
              display_active   <= pri_active;
              octave_up_out    <= pri_up;
              octave_down_out  <= pri_down;
              source_sel       <= pri_sel;
            end else begin
              state <= LIVE_HOLD;
              timer <= HOLD_LOAD;
            end
          end
          LIVE_HOLD: begin
            if (live_valid || timer == '0) begin
              state            <= pri_state;
              base_note_id_out <= pri_note;
              semitone_out     <= pri_semi;
              display_active   <= pri_active;
              octave_up_out    <= pri_up;
              octave_down_out  <= pri_down;
              source_sel       <= pri_sel;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            // IDLE and PB both simply follow the live-over-playback priority.
            state            <= pri_state;
            base_note_id_out <= pri_note;
            semitone_out     <= pri_semi;
            display_active   <= pri_active;
            octave_up_out    <= pri_up;
            octave_down_out  <= pri_down;
            source_sel       <= pri_sel;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Randomized bench for display_source_arbiter against a cycle-level model
// that tracks remaining message/hold time as plain counters.
module tb_display_source_arbiter;

  localparam int HOLD = 4;
  localparam int MSGC = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       live_valid, live_oct_up, live_oct_down;
  logic [2:0] live_note_id;
  logic [1:0] live_semitone;
  logic       pb_valid, pb_oct_up, pb_oct_down;
  logic [2:0] pb_note_id;
  logic [1:0] pb_semitone;
  logic       msg_req;
  logic [2:0] msg_note_id;
  logic [1:0] msg_semitone;
  logic       msg_ack;
  logic [2:0] base_note_id_out;
  logic [1:0] semitone_out;
  logic       display_active, octave_up_out, octave_down_out;
  logic [1:0] source_sel;

  display_source_arbiter #(.HOLD_CYCLES(HOLD), .MSG_CYCLES(MSGC)) dut (
    .clk(clk), .rst_n(rst_n),
    .live_valid(live_valid), .live_note_id(live_note_id), .live_semitone(live_semitone),
    .live_oct_up(live_oct_up), .live_oct_down(live_oct_down),
    .pb_valid(pb_valid), .pb_note_id(pb_note_id), .pb_semitone(pb_semitone),
    .pb_oct_up(pb_oct_up), .pb_oct_down(pb_oct_down),
    .msg_req(msg_req), .msg_note_id(msg_note_id), .msg_semitone(msg_semitone),
    .msg_ack(msg_ack), .base_note_id_out(base_note_id_out), .semitone_out(semitone_out),
    .display_active(display_active), .octave_up_out(octave_up_out),
    .octave_down_out(octave_down_out), .source_sel(source_sel)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what is on screen plus how long the message/hold still runs.
  int       m_ack, m_sel, m_note, m_semi, m_act, m_up, m_dn;
  bit       msg_on, live_mode, holding;
  int       msg_left, hold_left;

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h (ack,sel,note,semi,act,up,dn)", tag, $time, got, exp);
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {msg_ack, source_sel, base_note_id_out, semitone_out, display_active,
            octave_up_out, octave_down_out};
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_ack[0], m_sel[1:0], m_note[2:0], m_semi[1:0], m_act[0], m_up[0], m_dn[0]};
  endfunction

  function automatic int fix_semi(input int s);
    return (s == 3) ? 0 : s;
  endfunction

  task automatic show(input int sel, input int note, input int semi, input int act,
                      input int up, input int dn);
    m_sel = sel; m_note = note; m_semi = fix_semi(semi); m_act = act; m_up = up; m_dn = dn;
  endtask

  task automatic model_reset();
    m_ack = 0; show(0, 0, 0, 0, 0, 0);
    msg_on = 0; live_mode = 0; holding = 0; msg_left = 0; hold_left = 0;
  endtask

  task automatic pick();
    holding = 0;
    if (live_valid) begin
      live_mode = 1; show(1, live_note_id, live_semitone, 1, live_oct_up, live_oct_down);
    end else if (pb_valid) begin
      live_mode = 0; show(2, pb_note_id, pb_semitone, 1, pb_oct_up, pb_oct_down);
    end else begin
      live_mode = 0; show(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic accept();
    msg_on = 1; msg_left = MSGC; m_ack = 1; live_mode = 0; holding = 0;
    show(3, msg_note_id, msg_semitone, 1, 0, 0);
  endtask

  // One clock edge of the reference behaviour, using the inputs now applied.
  task automatic model_step();
    m_ack = 0;
    if (msg_on) begin
      msg_left--;
      if (msg_left == 0) begin
        if (msg_req) accept();
        else begin msg_on = 0; pick(); end
      end
    end else if (msg_req) begin
      accept();
    end else if (live_valid) begin
      pick();
    end else if (live_mode) begin
      if (holding) begin
        hold_left--;
        if (hold_left == 0) pick();
      end else if (HOLD == 0) begin
        pick();
      end else begin
        holding = 1; hold_left = HOLD;
      end
    end else begin
      pick();
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk(tag, dut_vec(), exp_vec());
  endtask

  initial begin
    rst_n = 1'b0;
    live_valid = 0; live_note_id = 0; live_semitone = 0; live_oct_up = 0; live_oct_down = 0;
    pb_valid = 0; pb_note_id = 0; pb_semitone = 0; pb_oct_up = 0; pb_oct_down = 0;
    msg_req = 0; msg_note_id = 0; msg_semitone = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset", dut_vec(), exp_vec());
    rst_n = 1'b1;
    step("idle");

    // Message interrupted by reset during its third visible cycle.
    live_valid = 1; live_note_id = 3; live_semitone = 1;
    msg_req = 1; msg_note_id = 6; msg_semitone = 2;
    step("msg_ack");
    msg_req = 0;
    step("msg_c2");
    step("msg_c3");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async", dut_vec(), exp_vec());
    live_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst1");
    step("post_rst2");

    // Randomized traffic; the requester drops msg_req after seeing the ack.
    for (int i = 0; i < 4000; i++) begin
      if (msg_req && m_ack != 0) msg_req = 0;
      else if (!msg_req && $urandom_range(0, 24) == 0) begin
        msg_req = 1; msg_note_id = 3'($urandom); msg_semitone = 2'($urandom);
      end
      if ($urandom_range(0, 7) == 0) live_valid = ~live_valid;
      if ($urandom_range(0, 3) == 0) begin
        live_note_id = 3'($urandom); live_semitone = 2'($urandom);
        live_oct_up = 1'($urandom); live_oct_down = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) pb_valid = ~pb_valid;
      if ($urandom_range(0, 2) == 0) begin
        pb_note_id = 3'($urandom); pb_semitone = 2'($urandom);
        pb_oct_up = 1'($urandom); pb_oct_down = 1'($urandom);
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
